decoder_scan_ctrl: RTL and testbench
====================================

DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, giving the cycles en is held high per channel (legal 1..255).
REQ-002 The block SHALL have parameter GAP, default 1, giving the blanking cycles with en low between channels (legal 0..255).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk, input, 1, rising-edge clock.
REQ-004 rst_n, input, 1: asynchronous active-low reset.
REQ-005 start, input, 1: begin a scan when IDLE.
REQ-006 stop, input, 1: abort the scan in progress.
REQ-007 cont, input, 1: 1 = repeat passes continuously, 0 = single pass; latched on start.
REQ-008 mask, input, 4: channel enable, bit i enables decoder output i; latched on start.
REQ-009 A, output, 2: channel select for the downstream 2-to-4 decoder.
REQ-010 en, output, 1: decoder enable.
REQ-011 busy, output, 1: high in any state other than IDLE.
REQ-012 done, output, 1: one-cycle pulse when a single pass completes normally.

Function
REQ-013 All outputs SHALL be driven directly from flops; none SHALL be combinational from inputs.
REQ-014 FSM states SHALL be IDLE, ACTIVE and BLANK.
REQ-015 IDLE SHALL drive en=0 and A=00, and hold A=00 while IDLE.
REQ-016 In IDLE, start=1 with mask!=0 at edge t SHALL latch mask and cont and enter ACTIVE, with A = lowest set mask bit and en=1 from the cycle after t (1-cycle latency).
REQ-017 In IDLE, start=1 with mask==0 SHALL be ignored: the FSM stays in IDLE with no busy and no done.
REQ-018 ACTIVE SHALL hold en=1 and A constant for exactly DWELL cycles, counted by an 8-bit counter.
REQ-019 After DWELL cycles in ACTIVE:
- GAP>0: enter BLANK, en=0, A held, for exactly GAP cycles.
- GAP=0: advance directly to the next channel in ACTIVE; en stays 1 with no low cycle.
REQ-020 Channel advance SHALL select the next set bit of the latched mask in ascending order, wrapping 3 to 0.
REQ-021 A pass SHALL end when the highest set latched-mask bit completes ACTIVE plus BLANK.
- cont latched = 1: restart at the lowest set bit with no extra cycles.
- cont latched = 0: enter IDLE, with done=1 in the first IDLE cycle only.
REQ-022 With a single set mask bit and cont=1, A SHALL stay constant and en SHALL repeat the pattern DWELL high, GAP low.
REQ-023 start while busy SHALL be ignored; changes to mask and cont while busy SHALL have no effect until the next accepted start.
REQ-024 stop=1 sampled in ACTIVE or BLANK SHALL force IDLE at the next edge (en=0, A=00, busy=0), with no done.
REQ-025 stop SHALL take priority over start in the same cycle; stop in IDLE SHALL have no effect.
REQ-026 The dwell/gap counter SHALL clear on every state change so that no partial count carries over.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, A=00, en=0, busy=0, done=0, counter=0, latched mask=0000 and latched cont=0.
REQ-028 Reset asserted mid-ACTIVE or mid-BLANK SHALL abort the scan with no done pulse.
REQ-029 After rst_n deasserts, the block SHALL remain in IDLE until a valid start.

Verification (DWELL=4, GAP=1 unless stated)
REQ-030 mask=1111, cont=0, one-cycle start -> A=00,01,10,11 each with en=1 for 4 cycles then en=0 for 1 cycle; busy=1 for 20 cycles; done=1 for exactly 1 cycle on cycle 21, then A=00.
REQ-031 mask=1010, cont=0, start -> A=01 for 4 en-high cycles, 1 blank cycle, then A=11 for 4 en-high cycles, 1 blank cycle; done on cycle 11; channels 00 and 10 never selected.
REQ-032 mask=0100, cont=1, start; stop pulse after 12 cycles -> A=10 throughout with en pattern 1111 0 repeating; en=0, A=00, busy=0 on the cycle after stop; done never asserted.
REQ-033 start with mask=0000, then start with stop=1 and mask=0001 -> both ignored: busy, en and done stay 0.
REQ-034 rst_n pulsed low mid-ACTIVE on channel 01 -> en=0, A=00, busy=0 during the low pulse before any clock edge; no done; the next start scans from the lowest set bit.
REQ-035 GAP=0 instance, mask=1111, cont=0 -> en=1 continuously for 16 cycles while A steps 00..11 every 4 cycles; done on cycle 17.

Source files
------------

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//   Scans the enabled outputs of a downstream 2-to-4 decoder. Each enabled
//   channel is selected on A and held with en high for DWELL cycles. It is
//   then followed by GAP blanking cycles with en low and A held.
//   A pass visits the set bits of the latched mask in ascending order. When
//   cont is latched high, passes repeat until stop is asserted.
//
// Parameters
//   DWELL : cycles en is held high per channel (1..255)
//   GAP   : blanking cycles between channels (0..255)
//
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : begin a scan when idle (ignored if mask==0 or stop is high)
//   stop  : abort the scan in progress
//   cont  : 1 = continuous passes, 0 = single pass (latched on start)
//   mask  : channel enables (latched on start)
//   A     : channel select to the decoder
//   en    : decoder enable
//   busy  : high whenever the scanner is not idle
//   done  : one-cycle pulse after a single pass completes normally
module decoder_scan_ctrl #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    input  logic [3:0] mask,
    output logic [1:0] A,
    output logic       en,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] mask_q;
    logic       cont_q;

    logic       phase_end;
    logic       nxt_found;
    logic [1:0] nxt_ch;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        lowest_set = 2'd0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (m[i-1]) lowest_set = 2'(i - 1);
        end
    endfunction

    // Next enabled channel strictly above the current one. When none is
    // found, the current pass has reached its last channel.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = A;
        for (int unsigned i = 4; i > 0; i--) begin
            if (mask_q[i-1] && ((i - 1) > 32'(A))) begin
                nxt_found = 1'b1;
                nxt_ch    = 2'(i - 1);
            end
        end
    end

    always_comb begin
        phase_end = 1'b0;
        if (state == ACTIVE && cnt == DWELL_LAST) phase_end = 1'b1;
        if (state == BLANK  && cnt == GAP_LAST)   phase_end = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            A      <= '0;
            en     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            mask_q <= '0;
            cont_q <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    A    <= '0;
                    en   <= 1'b0;
                    busy <= 1'b0;
                    cnt  <= '0;
                    if (start && !stop && (mask != '0)) begin
                        mask_q <= mask;
                        cont_q <= cont;
                        A      <= lowest_set(mask);
                        en     <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ACTIVE;
                    end
                end
                ACTIVE, BLANK: begin
                    if (stop) begin
                        state <= IDLE;
                        A     <= '0;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (phase_end) begin
                        // Every phase transition restarts the count, including
                        // an ACTIVE->ACTIVE channel step when GAP is zero.
                        cnt <= '0;
                        if (state == ACTIVE && GAP != 0) begin
                            state <= BLANK;
                            en    <= 1'b0;
                        end else if (nxt_found) begin
                            state <= ACTIVE;
                            A     <= nxt_ch;
                            en    <= 1'b1;
                        end else if (cont_q) begin
                            state <= ACTIVE;
                            A     <= lowest_set(mask_q);
                            en    <= 1'b1;
                        end else begin
                            state <= IDLE;
                            A     <= '0;
                            en    <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
module tb_decoder_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       cont = 1'b0;
    logic [3:0] mask = 4'd0;

    logic [1:0] a0, a1;
    logic       en0, en1, busy0, busy1, done0, done1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DWELL(4), .GAP(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
        .mask(mask), .A(a0), .en(en0), .busy(busy0), .done(done0)
    );

    decoder_scan_ctrl #(.DWELL(4), .GAP(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
        .mask(mask), .A(a1), .en(en1), .busy(busy1), .done(done1)
    );

    // Reference model: a scan is a position within a pass. A pass is
    // (number of set mask bits) slots of DWELL+GAP cycles each.
    int         md[2] = '{4, 4};
    int         mg[2] = '{1, 0};
    int         pos[2];
    logic       mb[2];
    logic       mdone[2];
    logic [3:0] lm[2];
    logic       lc[2];

    function automatic int nth_set(input logic [3:0] m, input int n);
        int c = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (c == n) return i;
                c++;
            end
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                pos[k] = 0; mb[k] = 0; mdone[k] = 0; lm[k] = 0; lc[k] = 0;
            end else begin
                mdone[k] = 0;
                if (mb[k]) begin
                    if (stop) begin
                        mb[k] = 0;
                    end else begin
                        pos[k]++;
                        if (pos[k] == $countones(lm[k]) * (md[k] + mg[k])) begin
                            pos[k] = 0;
                            if (!lc[k]) begin
                                mb[k] = 0;
                                mdone[k] = 1;
                            end
                        end
                    end
                end else if (start && !stop && mask != 0) begin
                    lm[k] = mask; lc[k] = cont; mb[k] = 1; pos[k] = 0;
                end
            end
        end
    end

    function automatic int exp_a(input int k);
        if (!mb[k]) return 0;
        return nth_set(lm[k], pos[k] / (md[k] + mg[k]));
    endfunction

    function automatic int exp_en(input int k);
        if (!mb[k]) return 0;
        return ((pos[k] % (md[k] + mg[k])) < md[k]) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #2;
        chk("u0.A",    int'(a0),    exp_a(0));
        chk("u0.en",   int'(en0),   exp_en(0));
        chk("u0.busy", int'(busy0), int'(mb[0]));
        chk("u0.done", int'(done0), int'(mdone[0]));
        chk("u1.A",    int'(a1),    exp_a(1));
        chk("u1.en",   int'(en1),   exp_en(1));
        chk("u1.busy", int'(busy1), int'(mb[1]));
        chk("u1.done", int'(done1), int'(mdone[1]));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #3;
        chk("reset_busy", int'(busy0), 0);
        chk("reset_en",   int'(en0),   0);
        chk("reset_A",    int'(a0),    0);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);

        // Full mask, single pass.
        mask = 4'b1111; cont = 0; start = 1;
        tick();                                   // cycle 1
        start = 0;
        chk("f_c1_A", int'(a0), 0); chk("f_c1_en", int'(en0), 1);
        ticks(4);                                 // cycle 5
        chk("f_c5_en", int'(en0), 0); chk("f_c5_A", int'(a0), 0);
        tick();                                   // cycle 6
        chk("f_c6_A", int'(a0), 1); chk("f_c6_en", int'(en0), 1);
        ticks(10);                                // cycle 16
        chk("g0_c16_A", int'(a1), 3); chk("g0_c16_en", int'(en1), 1);
        tick();                                   // cycle 17
        chk("g0_c17_done", int'(done1), 1);
        ticks(3);                                 // cycle 20
        chk("f_c20_A", int'(a0), 3); chk("f_c20_en", int'(en0), 0);
        chk("f_c20_busy", int'(busy0), 1);
        tick();                                   // cycle 21
        chk("f_c21_done", int'(done0), 1); chk("f_c21_busy", int'(busy0), 0);
        tick();
        chk("f_c22_done", int'(done0), 0);
        ticks(2);

        // Sparse mask skips channels 0 and 2.
        mask = 4'b1010; start = 1;
        tick();
        start = 0;
        chk("s_c1_A", int'(a0), 1);
        ticks(5);
        chk("s_c6_A", int'(a0), 3);
        ticks(5);
        chk("s_c11_done", int'(done0), 1);
        ticks(2);

        // Continuous single channel, then stop.
        mask = 4'b0100; cont = 1; start = 1;
        tick();
        start = 0;
        mask = 4'b0001; cont = 0;                 // must not affect the scan
        ticks(11);
        chk("c_c12_A", int'(a0), 2);
        stop = 1;
        tick();
        stop = 0;
        chk("c_stop_busy", int'(busy0), 0); chk("c_stop_A", int'(a0), 0);
        ticks(2);

        // Ignored starts.
        mask = 4'b0000; start = 1;
        tick();
        mask = 4'b0001; stop = 1;
        tick();
        start = 0; stop = 0;
        chk("ign_busy", int'(busy0), 0);
        ticks(2);

        // Asynchronous reset mid-ACTIVE on channel 1.
        mask = 4'b0010; start = 1;
        tick();
        start = 0;
        tick();
        #1 rst_n = 0;
        #1;
        chk("ar_busy", int'(busy0), 0); chk("ar_en", int'(en0), 0);
        chk("ar_A", int'(a0), 0);
        #2 rst_n = 1;
        ticks(2);
        mask = 4'b0110; start = 1;
        tick();
        start = 0;
        chk("ar_restart_A", int'(a0), 1);
        ticks(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            mask  = 4'($urandom_range(0, 15));
            cont  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 0;
                #2 rst_n = 1;
            end
            tick();
        end
        start = 0; stop = 0;
        ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
